psd_divider_seq: RTL and testbench

Parametrised sequential integer divider, restoring radix-2, one quotient bit per clock. It generalises the lab's unsigned start/stop divider with four additions: a runtime signed/unsigned mode, a busy/done handshake, divide-by-zero detection and signed-overflow detection. It sits as a multi-cycle arithmetic unit beside the datapath and is driven by a controller that issues `start` and waits for `done`.

---
 rtl/psd_divider_seq.sv | 169 ++++++++++++++++
 tb/tb_psd_divider_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psd_divider_seq.sv
// psd_divider_seq: restoring radix-2 sequential divider, one quotient bit
// per clock, signed/unsigned mode with divide-by-zero and overflow status.
module psd_divider_seq #(
    parameter int NBITS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] rest,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] rem_q, rem_d;
    logic [NBITS-1:0] dvd_q, dvd_d;
    logic [NBITS-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [NBITS-1:0] quo_q, quo_d;
    logic [NBITS-1:0] rst_q, rst_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             of_q, of_d;

    logic             a_neg, b_neg;
    logic [NBITS-1:0] a_abs, b_abs;
    logic [NBITS-1:0] q_fix, r_fix;
    logic [NBITS:0]   shifted, trial;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign rest        = rst_q;
    assign div_by_zero = dz_q;
    assign overflow    = of_q;

    // Operand magnitudes, trial subtract and sign fix-up of the raw result.
    always_comb begin
        a_neg   = signed_mode & dividend[NBITS-1];
        b_neg   = signed_mode & divisor[NBITS-1];
        a_abs   = a_neg ? -dividend : dividend;
        b_abs   = b_neg ? -divisor : divisor;
        shifted = {rem_q, dvd_q[NBITS-1]};
        trial   = shifted - {1'b0, dsr_q};
        q_fix   = qneg_q ? -dvd_q : dvd_q;
        r_fix   = rneg_q ? -rem_q : rem_q;
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        rst_d   = rst_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        of_d    = of_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d  = '0;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    ovf_d  = signed_mode
                           && dividend == {1'b1, {(NBITS-1){1'b0}}}
                           && divisor == '1;
                    if (divisor == '0) begin
                        zero_d  = 1'b1;
                        dvd_d   = dividend;
                        dsr_d   = '0;
                        state_d = FIX;
                    end else begin
                        zero_d  = 1'b0;
                        dvd_d   = a_abs;
                        dsr_d   = b_abs;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = trial[NBITS] ? shifted[NBITS-1:0]
                                     : trial[NBITS-1:0];
                dvd_d = {dvd_q[NBITS-2:0], ~trial[NBITS]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NBITS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quo_d = '1;
                    rst_d = dvd_q;
                    dz_d  = 1'b1;
                    of_d  = 1'b0;
                end else begin
                    quo_d = q_fix;
                    rst_d = r_fix;
                    dz_d  = 1'b0;
                    of_d  = ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            of_q    <= of_d;
        end
    end

endmodule

// File: tb/tb_psd_divider_seq.sv
// tb_psd_divider_seq: randomized and directed checks of psd_divider_seq
// against an arithmetic reference model; 32-bit and 8-bit instances.
module tb_psd_divider_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, signed_mode;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero, overflow;
    logic [31:0] quotient, rest;

    logic        s8_start, s8_mode;
    logic [7:0]  s8_dvd, s8_dsr;
    logic        s8_busy, s8_done, s8_z, s8_o;
    logic [7:0]  s8_q, s8_r;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    psd_divider_seq #(.NBITS(32)) dut (
        .clock(clock), .reset(reset), .start(start),
        .signed_mode(signed_mode), .dividend(dividend),
        .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .rest(rest),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    psd_divider_seq #(.NBITS(8)) dut8 (
        .clock(clock), .reset(reset), .start(s8_start),
        .signed_mode(s8_mode), .dividend(s8_dvd),
        .divisor(s8_dsr), .busy(s8_busy), .done(s8_done),
        .quotient(s8_q), .rest(s8_r),
        .div_by_zero(s8_z), .overflow(s8_o)
    );

    function automatic void model(input bit m, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output logic z, output logic o);
        int sa, sb;
        sa = a;
        sb = b;
        z = 1'b0;
        o = 1'b0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (m && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
            o = 1'b1;
        end else if (m) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic issue(input bit m, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        signed_mode = m;
        dividend = a;
        divisor = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcnt,
                             output bit to);
        cyc = 0;
        bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(negedge clock);
            cyc++;
        end
        to = !done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        dividend = 0;
        divisor = 0;
        s8_start = 1'b0;
        s8_mode = 1'b0;
        s8_dvd = 0;
        s8_dsr = 0;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, rest} !== '0) begin
            bad++;
            $display("FAIL reset32 got b=%b d=%b z=%b o=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, overflow, quotient, rest);
        end
        total++;
        if ({s8_busy, s8_done, s8_z, s8_o, s8_q, s8_r} !== '0) begin
            bad++;
            $display("FAIL reset8 got q=%h r=%h b=%b d=%b want all 0",
                     s8_q, s8_r, s8_busy, s8_done);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        bit          tm [6];
        logic [31:0] eq [6];
        logic [31:0] er [6];
        logic        ez [6];
        logic        eo [6];
        int          el [6];
        int cyc, bcnt;
        bit to;
        ta = '{100, 32'hFFFF_FFF9, 7, 32'h1234_5678,
               32'h8000_0000, 32'h8000_0000};
        tb = '{7, 2, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tm = '{0, 1, 1, 0, 1, 0};
        eq = '{14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               32'h8000_0000, 0};
        er = '{2, 32'hFFFF_FFFF, 1, 32'h1234_5678, 0, 32'h8000_0000};
        ez = '{0, 0, 0, 1, 0, 0};
        eo = '{0, 0, 0, 0, 1, 0};
        el = '{33, 33, 33, 1, 33, 33};
        for (int i = 0; i < 6; i++) begin
            issue(tm[i], ta[i], tb[i]);
            wait_done(cyc, bcnt, to);
            total++;
            if (to || cyc != el[i] || bcnt != el[i]) begin
                bad++;
                $display("FAIL dir%0d latency got cyc=%0d busy=%0d to=%b want %0d",
                         i, cyc, bcnt, to, el[i]);
            end
            total++;
            if ({quotient, rest, div_by_zero, overflow} !==
                {eq[i], er[i], ez[i], eo[i]}) begin
                bad++;
                $display("FAIL dir%0d result got q=%h r=%h z=%b o=%b want q=%h r=%h z=%b o=%b",
                         i, quotient, rest, div_by_zero, overflow,
                         eq[i], er[i], ez[i], eo[i]);
            end
            @(negedge clock);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq[i]) begin
                bad++;
                $display("FAIL dir%0d pulse got done=%b busy=%b q=%h want 0 0 %h",
                         i, done, busy, quotient, eq[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        bit to;
        issue(0, 100, 7);
        repeat (8) @(negedge clock);
        start = 1'b1;
        dividend = 9;
        divisor = 3;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, bcnt, to);
        total++;
        if (to || quotient !== 14 || rest !== 2) begin
            bad++;
            $display("FAIL busy_start got q=%0d r=%0d to=%b want 14 2",
                     quotient, rest, to);
        end
        start = 1'b1;
        signed_mode = 1'b0;
        dividend = 9;
        divisor = 3;
        @(negedge clock);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept got done=%b busy=%b want 0 1",
                     done, busy);
        end
        wait_done(cyc, bcnt, to);
        total++;
        if (to || cyc != 33 || quotient !== 3 || rest !== 0) begin
            bad++;
            $display("FAIL b2b got q=%0d r=%0d cyc=%0d want 3 0 33",
                     quotient, rest, cyc);
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        issue(0, 100, 7);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, div_by_zero, overflow, quotient, rest} !== '0) begin
            bad++;
            $display("FAIL abort got b=%b q=%h r=%h want all 0",
                     busy, quotient, rest);
        end
        @(negedge clock);
        start = 1'b1;
        dividend = 5;
        divisor = 1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen || quotient !== 0) begin
            bad++;
            $display("FAIL abort_done got seen=%b q=%h want 0 0",
                     seen, quotient);
        end
    endtask

    task automatic test_nbits8;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        bit         tm [3];
        logic [7:0] eq [3];
        logic [7:0] er [3];
        logic       eo [3];
        int cyc;
        ta = '{255, 8'h80, 8'h80};
        tb = '{1, 8'hFF, 3};
        tm = '{0, 1, 1};
        eq = '{255, 8'h80, 8'hD6};
        er = '{0, 0, 8'hFE};
        eo = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            s8_start = 1'b1;
            s8_mode = tm[i];
            s8_dvd = ta[i];
            s8_dsr = tb[i];
            @(negedge clock);
            s8_start = 1'b0;
            cyc = 0;
            while (!s8_done && cyc < 50) begin
                @(negedge clock);
                cyc++;
            end
            total++;
            if (cyc != 9 || {s8_q, s8_r, s8_z, s8_o} !==
                {eq[i], er[i], 1'b0, eo[i]}) begin
                bad++;
                $display("FAIL n8_%0d got q=%h r=%h o=%b cyc=%0d want %h %h %b 9",
                         i, s8_q, s8_r, s8_o, cyc, eq[i], er[i], eo[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, q, r;
        logic z, o;
        bit m, to;
        int cyc, bcnt;
        for (int i = 0; i < 60; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            model(m, a, b, q, r, z, o);
            issue(m, a, b);
            wait_done(cyc, bcnt, to);
            total++;
            if (to || cyc != (z ? 1 : 33) ||
                {quotient, rest, div_by_zero, overflow} !== {q, r, z, o}) begin
                bad++;
                $display("FAIL rnd%0d m=%b a=%h b=%h got q=%h r=%h z=%b o=%b cyc=%0d want q=%h r=%h z=%b o=%b",
                         i, m, a, b, quotient, rest, div_by_zero, overflow,
                         cyc, q, r, z, o);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_abort;
        test_nbits8;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
